// File: rtl/uart_csr_pkg.sv
// uart_csr_pkg: register offsets, bit indices and enums shared by the UART CSR block
package uart_csr_pkg;
    localparam int CFG_W = 5;
    localparam logic [7:0] OFF_TXDATA   = 8'h00;
    localparam logic [7:0] OFF_RXDATA   = 8'h04;
    localparam logic [7:0] OFF_CFG      = 8'h08;
    localparam logic [7:0] OFF_CTRL     = 8'h0C;
    localparam logic [7:0] OFF_STAT     = 8'h10;
    localparam logic [7:0] OFF_INT_STAT = 8'h14;
    localparam logic [7:0] OFF_INT_EN   = 8'h18;
    localparam int CTRL_TX_EN    = 0;
    localparam int CTRL_RX_EN    = 1;
    localparam int CTRL_TX_FLUSH = 2;
    localparam int CTRL_RX_FLUSH = 3;
    localparam int INT_TX_DONE   = 0;
    localparam int INT_RX_AVAIL  = 1;
    localparam int INT_PARITY    = 2;
    localparam int INT_OVERRUN   = 3;
    typedef enum logic [2:0] {
        R_TXDATA, R_RXDATA, R_CFG, R_CTRL, R_STAT, R_INT_STAT, R_INT_EN, R_NONE
    } reg_e;
endpackage

// File: rtl/uart_apb_csr_fifo_if.sv
// uart_apb_csr_fifo_if: APB slave bus bundle for the UART CSR block
interface uart_apb_csr_fifo_if #(parameter int ADDR_W = 5);
    logic psel, penable, pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0] pwdata, prdata;
    logic pready, pslverr;
    modport master(output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslverr);
    modport slave(input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO with flush, level and wrap-bit full detection
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign do_pop = pop && !empty;
    // a pop in the same cycle frees the slot a push into a full FIFO needs
    assign do_push = push && (!full || do_pop);
    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];
    always_ff @(posedge pclk) begin
        if (preset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
    always_ff @(posedge pclk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/uart_apb_csr_fifo.sv
// uart_apb_csr_fifo: APB register bank with TX/RX FIFOs, W1C interrupt status and irq
module uart_apb_csr_fifo
    import uart_csr_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8,
    parameter int ADDR_W   = 5
) (
    input  logic              pclk,
    input  logic              preset,
    uart_apb_csr_fifo_if.slave apb,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic              tx_done,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_push,
    input  logic              rx_parity_err,
    output logic [CFG_W-1:0]  cfg_out,
    output logic              irq
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    logic [CFG_W-1:0] cfg_q;
    logic [1:0] ctrl_q;
    logic [3:0] int_stat, int_en, int_set, int_clr;
    logic [ADDR_W-1:0] word_addr;
    reg_e rsel;
    logic access, wr, rd, err;
    logic tx_push, tx_pop, tx_flush, tx_full, tx_empty;
    logic rx_pop, rx_flush, rx_full, rx_empty, rx_ok, rx_store, rx_overrun;
    logic [TAW:0] tx_level;
    logic [RAW:0] rx_level;
    logic [DATA_W-1:0] rx_head;
    logic [31:0] stat;
    logic unused_bits;
    assign unused_bits = ^{apb.pwdata, apb.paddr[1:0]};
    assign word_addr = {apb.paddr[ADDR_W-1:2], 2'b00};
    assign rsel = word_addr == ADDR_W'(OFF_TXDATA)   ? R_TXDATA   :
                  word_addr == ADDR_W'(OFF_RXDATA)   ? R_RXDATA   :
                  word_addr == ADDR_W'(OFF_CFG)      ? R_CFG      :
                  word_addr == ADDR_W'(OFF_CTRL)     ? R_CTRL     :
                  word_addr == ADDR_W'(OFF_STAT)     ? R_STAT     :
                  word_addr == ADDR_W'(OFF_INT_STAT) ? R_INT_STAT :
                  word_addr == ADDR_W'(OFF_INT_EN)   ? R_INT_EN   : R_NONE;
    assign access = apb.psel && apb.penable;
    assign wr = access && apb.pwrite;
    assign rd = access && !apb.pwrite;
    assign tx_valid = ctrl_q[CTRL_TX_EN] && !tx_empty;
    assign tx_pop = tx_valid && tx_ready;
    assign err = access && (rsel == R_NONE ||
                            (wr && (rsel == R_RXDATA || rsel == R_STAT)) ||
                            (wr && rsel == R_TXDATA && tx_full && !tx_pop) ||
                            (rd && rsel == R_RXDATA && rx_empty));
    assign tx_push = wr && rsel == R_TXDATA && !err;
    assign rx_pop = rd && rsel == R_RXDATA && !err;
    assign tx_flush = wr && rsel == R_CTRL && apb.pwdata[CTRL_TX_FLUSH];
    assign rx_flush = wr && rsel == R_CTRL && apb.pwdata[CTRL_RX_FLUSH];
    // a flushed push is neither stored nor counted as an overrun
    assign rx_ok = rx_push && ctrl_q[CTRL_RX_EN] && !rx_flush;
    assign rx_store = rx_ok && (!rx_full || rx_pop);
    assign rx_overrun = rx_ok && rx_full && !rx_pop;
    always_comb begin
        int_set = '0;
        int_set[INT_TX_DONE] = tx_done;
        int_set[INT_RX_AVAIL] = rx_store;
        int_set[INT_PARITY] = rx_store && rx_parity_err;
        int_set[INT_OVERRUN] = rx_overrun;
    end
    assign int_clr = (wr && rsel == R_INT_STAT) ? apb.pwdata[3:0] : '0;
    uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .pclk(pclk), .preset(preset), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
        .din(apb.pwdata[DATA_W-1:0]), .dout(tx_data), .full(tx_full), .empty(tx_empty),
        .level(tx_level)
    );
    uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .pclk(pclk), .preset(preset), .push(rx_store), .pop(rx_pop), .flush(rx_flush),
        .din(rx_data), .dout(rx_head), .full(rx_full), .empty(rx_empty), .level(rx_level)
    );
    always_ff @(posedge pclk) begin
        if (preset) begin
            cfg_q <= '0;
            ctrl_q <= '0;
            int_en <= '0;
            int_stat <= '0;
            irq <= 1'b0;
        end else begin
            if (wr && rsel == R_CFG) cfg_q <= apb.pwdata[CFG_W-1:0];
            if (wr && rsel == R_CTRL) ctrl_q <= apb.pwdata[CTRL_RX_EN:CTRL_TX_EN];
            if (wr && rsel == R_INT_EN) int_en <= apb.pwdata[3:0];
            int_stat <= (int_stat & ~int_clr) | int_set;
            irq <= |(int_stat & int_en);
        end
    end
    assign stat = {8'd0, 8'(rx_level), 8'(tx_level), 4'd0, rx_full, rx_empty, tx_full, tx_empty};
    assign apb.prdata = !(rd && !err)         ? '0              :
                        rsel == R_RXDATA      ? 32'(rx_head)    :
                        rsel == R_CFG         ? 32'(cfg_q)      :
                        rsel == R_CTRL        ? 32'(ctrl_q)     :
                        rsel == R_STAT        ? stat            :
                        rsel == R_INT_STAT    ? 32'(int_stat)   :
                        rsel == R_INT_EN      ? 32'(int_en)     : '0;
    assign apb.pready = 1'b1;
    assign apb.pslverr = err;
    assign cfg_out = cfg_q;
endmodule
